// File: rtl/seqdet_sched.sv
// Round-robin scheduler sharing one serial "1001" Mealy detector among N_REQ requesters.
// Build option: define SEQDET_FIXED_PRIO_EN for fixed lowest-index-wins arbitration.
module seqdet_sched #(
  parameter  int N_REQ = 4,
  parameter  int W     = 16,
  parameter  int CNT_W = 3,
  localparam int IDW   = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ*W-1:0]   data,
  output logic [N_REQ-1:0]     ack,
  output logic                 busy,
  output logic                 res_valid,
  output logic [IDW-1:0]       res_id,
  output logic [CNT_W-1:0]     res_count,
  output logic                 res_hit
);

  localparam int            BW       = $clog2(W);
  localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  typedef enum logic [1:0] {S0, S1, S2, S3}    det_e;

  state_e           state_q, state_d;
  det_e             det_q, det_d;
  logic [W-1:0]     sh_q, sh_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDW-1:0]   res_id_q, res_id_d;

  logic [IDW-1:0]   win;
  logic [IDW-1:0]   idx;
  logic [W-1:0]     win_word;
  logic             din;
  logic             match;

`ifdef SEQDET_FIXED_PRIO_EN
  always_comb begin
    win = '0;
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = IDW'(i);
      if (req[idx]) win = idx;
    end
  end
`else
  logic [IDW-1:0] last_q, last_d;

  // Descending scan so the candidate closest after last_q is written last and wins.
  always_comb begin
    win = '0;
    idx = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = IDW'((int'(last_q) + i) % N_REQ);
      if (req[idx]) win = idx;
    end
  end
`endif

  always_comb begin
    win_word = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (IDW'(i) == win) win_word = data[i*W +: W];
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    det_d    = det_q;
    sh_d     = sh_q;
    bit_d    = bit_q;
    cnt_d    = cnt_q;
    res_id_d = res_id_q;
`ifndef SEQDET_FIXED_PRIO_EN
    last_d   = last_q;
`endif
    din      = sh_q[W-1];
    match    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|req) begin
          sh_d     = win_word;
          res_id_d = win;
          bit_d    = BIT_LAST;
          cnt_d    = '0;
          det_d    = S0;
`ifndef SEQDET_FIXED_PRIO_EN
          last_d   = win;
`endif
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        sh_d  = {sh_q[W-2:0], 1'b0};
        match = (det_q == S3) && din;
        unique case (det_q)
          S0: det_d = din ? S1 : S0;
          S1: det_d = din ? S1 : S2;
          S2: det_d = din ? S1 : S3;
          S3: det_d = din ? S1 : S0;
          default: det_d = S0;
        endcase
        if (match && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
        if (bit_q == '0) state_d = DONE;
        else             bit_d   = bit_q - 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      det_q    <= S0;
      sh_q     <= '0;
      bit_q    <= '0;
      cnt_q    <= '0;
      res_id_q <= '0;
`ifndef SEQDET_FIXED_PRIO_EN
      last_q   <= IDW'(N_REQ - 1);
`endif
    end else begin
      state_q  <= state_d;
      det_q    <= det_d;
      sh_q     <= sh_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
      res_id_q <= res_id_d;
`ifndef SEQDET_FIXED_PRIO_EN
      last_q   <= last_d;
`endif
    end
  end

  always_comb begin
    ack = '0;
    if (state_q == DONE) ack[res_id_q] = 1'b1;
  end

  assign busy      = (state_q != IDLE);
  assign res_valid = (state_q == DONE);
  assign res_id    = res_id_q;
  assign res_count = cnt_q;
  assign res_hit   = |cnt_q;

endmodule

// File: tb/tb_seqdet_sched.sv
// Self-checking bench for seqdet_sched: directed scenarios plus randomized traffic
// against a transaction-level model (word scan for "1001", cycle budget per job).
module tb_seqdet_sched;

  localparam int N_REQ = 4;
  localparam int W     = 16;
  localparam int IDW   = $clog2(N_REQ);

  logic               clk = 1'b0;
  logic               rst;
  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] data;

  logic [N_REQ-1:0] ack, ack2;
  logic             busy, busy2, res_valid, res_valid2, res_hit, res_hit2;
  logic [IDW-1:0]   res_id, res_id2;
  logic [2:0]       res_count;
  logic [1:0]       res_count2;

  always #5 clk = ~clk;

  seqdet_sched #(.N_REQ(N_REQ), .W(W), .CNT_W(3)) u_dut (
    .clk(clk), .rst(rst), .req(req), .data(data),
    .ack(ack), .busy(busy), .res_valid(res_valid), .res_id(res_id),
    .res_count(res_count), .res_hit(res_hit)
  );

  seqdet_sched #(.N_REQ(N_REQ), .W(W), .CNT_W(2)) u_dut_sat (
    .clk(clk), .rst(rst), .req(req), .data(data),
    .ack(ack2), .busy(busy2), .res_valid(res_valid2), .res_id(res_id2),
    .res_count(res_count2), .res_hit(res_hit2)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: m_t is cycles since grant (0 = idle, W+1 = result cycle).
  int m_t    = 0;
  int m_id   = 0;
  int m_raw  = 0;
  int m_last = N_REQ - 1;

  function automatic int count_1001(input logic [W-1:0] w);
    int c = 0;
    for (int i = W - 1; i >= 3; i--) if (w[i -: 4] == 4'b1001) c++;
    return c;
  endfunction

  function automatic int sat(input int c, input int cw);
    int mx = (1 << cw) - 1;
    return (c > mx) ? mx : c;
  endfunction

  function automatic int pick(input logic [N_REQ-1:0] r);
`ifdef SEQDET_FIXED_PRIO_EN
    for (int k = 0; k < N_REQ; k++) if (r[k]) return k;
`else
    for (int k = 1; k <= N_REQ; k++) if (r[(m_last + k) % N_REQ]) return (m_last + k) % N_REQ;
`endif
    return 0;
  endfunction

  task automatic model_edge();
    int win;
    if (rst) begin
      m_t = 0; m_id = 0; m_raw = 0; m_last = N_REQ - 1;
    end else if (m_t == 0) begin
      if (req != '0) begin
        win    = pick(req);
        m_id   = win;
        m_raw  = count_1001(data[win*W +: W]);
        m_last = win;
        m_t    = 1;
      end
    end else if (m_t == W + 1) begin
      m_t = 0;
    end else begin
      m_t++;
    end
  endtask

  task automatic compare();
    bit done = (m_t == W + 1);
    int unsigned exp_ack = done ? (1 << m_id) : 0;
    check("busy", busy, m_t != 0);
    check("res_valid", res_valid, done);
    check("ack", ack, exp_ack);
    check("res_id", res_id, m_id);
    check("sat_busy", busy2, m_t != 0);
    check("sat_ack", ack2, exp_ack);
    check("sat_id", res_id2, m_id);
    if (m_t == 0 || done) begin
      check("res_count", res_count, sat(m_raw, 3));
      check("res_hit", res_hit, m_raw != 0);
      check("sat_count", res_count2, sat(m_raw, 2));
      check("sat_hit", res_hit2, m_raw != 0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!res_valid && n < 3 * W);
    if (!res_valid) check("timeout", 0, 1);
  endtask

  function automatic logic [W-1:0] gen_word();
    logic [W-1:0] w;
    int off;
    w = W'($urandom);
    case ($urandom_range(0, 2))
      0: ;
      1: begin
        off = $urandom_range(0, 2);
        for (int i = 0; i < W; i++) w[i] = ((i + off) % 3 == 0);
      end
      default: w = w & W'($urandom) & W'($urandom);
    endcase
    return w;
  endfunction

  int n;

  initial begin
    rst = 1'b1; req = '0; data = '0;
    step(); step();
    rst = 1'b0;
    step();

    // Requester 0 alone with 16'h9249.
    req = 4'b0001; data[15:0] = 16'h9249;
    step();
    req = '0;
    wait_valid(n);
    check("d9249_lat", n, W);
    check("d9249_cnt", res_count, 5);
    check("d9249_sat", res_count2, 3);
    check("d9249_ack", ack, 4'b0001);
    check("d9249_id", res_id, 0);
    step();

    // Requester 2 with all-zero then all-one words.
    req = 4'b0100; data = '0;
    step(); req = '0;
    wait_valid(n);
    check("zero_cnt", res_count, 0);
    check("zero_hit", res_hit, 0);
    check("zero_id", res_id, 2);
    step();
    req = 4'b0100; data[32 +: 16] = 16'hFFFF;
    step(); req = '0;
    wait_valid(n);
    check("ones_cnt", res_count, 0);
    check("ones_hit", res_hit, 0);
    check("ones_id", res_id, 2);
    step();

    // All requests held high from reset.
    rst = 1'b1; step(); rst = 1'b0;
    req = '1; data = {4{16'h9249}};
    for (int j = 0; j < 5; j++) begin
      wait_valid(n);
`ifdef SEQDET_FIXED_PRIO_EN
      check("rr_id", res_id, 0);
`else
      check("rr_id", res_id, j % N_REQ);
`endif
      if (j > 0) check("rr_gap", n, W + 2);
    end
    req = '0;
    step(); step();

    // Reset during SHIFT cycle k+5 drops the job.
    req = 4'b0010; data[16 +: 16] = 16'h9249;
    step();
    for (int j = 0; j < 4; j++) step();
    rst = 1'b1;
    step();
    check("rst_busy", busy, 0);
    check("rst_ack", ack, 0);
    rst = 1'b0; req = 4'b1111;
    step();
    check("rst_regrant", res_id, 0);
    req = '0;
    wait_valid(n);
    step();

    // Requester 1 drops req and changes data after grant.
    req = 4'b0010; data[16 +: 16] = 16'h9249;
    step();
    step();
    data[16 +: 16] = 16'h0000;
    step();
    req = '0;
    wait_valid(n);
    check("drop_cnt", res_count, 5);
    check("drop_ack", ack, 4'b0010);
    step();

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      req = ($urandom_range(0, 3) == 0) ? '0 : N_REQ'($urandom);
      for (int i = 0; i < N_REQ; i++) data[i*W +: W] = gen_word();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seqdet_sched.md
# seqdet_sched

Round-robin scheduler that shares one serial "1001" Mealy pattern detector among `N_REQ` requesters. The block grants one requester at a time and captures its `W`-bit word. It serialises the word MSB-first through the internal detector, counts the overlapping matches, and returns the count with a one-cycle acknowledge to the winning requester. It sits between several parallel producers and the single sequential detector datapath.

## Interface
- `N_REQ`, 4: number of requesters (≥2).
- `W`, 16: bits per job word (≥4).
- `CNT_W`, 3: match-count width; the count saturates.
- `IDW`, `$clog2(N_REQ)`: requester-id width (derived; do not override).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous reset, active-high.
- `req` in `N_REQ`: level request; bit `i` belongs to requester `i`.
- `data` in `N_REQ*W`: requester `i` word at `[i*W +: W]`; sampled only at grant.
- `ack` out `N_REQ`: one-hot, one-cycle pulse to the served requester in the DONE cycle.
- `busy` out 1: high in SHIFT and DONE.
- `res_valid` out 1: one-cycle pulse; result fields are valid.
- `res_id` out `IDW`: index of the served requester.
- `res_count` out `CNT_W`: number of "1001" matches in the word.
- `res_hit` out 1: `res_count != 0`.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- **IDLE**
  - If `|req`, the arbiter picks a winner.
  - On that edge: latch the winner's word into the shift register, latch `res_id`, set bit counter = W-1, clear the match count, set the detector to S0, and go to SHIFT.
  - If `req == 0`, stay in IDLE.
- **SHIFT**
  - Each cycle the shift register MSB is the detector input `d`, then the register shifts left.
  - Detector transitions:
    - S0: 1→S1, 0→S0.
    - S1: 1→S1, 0→S2.
    - S2: 1→S1, 0→S3.
    - S3: 1→S1 and match; 0→S0.
  - The match is combinational (`state==S3 && d`). On a match the count increments, saturating at 2^CNT_W−1.
  - Matches overlap: "1001001" counts 2.
  - The detector restarts at S0 for every job. There is no carry-over between jobs.
  - After the bit with counter 0, go to DONE.
- **DONE**
  - `res_valid=1`, `ack[res_id]=1`, `res_count` and `res_hit` valid. Next state is IDLE.
  - `res_id`, `res_count`, and `res_hit` hold their values until the next grant.
- **Arbitration (default)**
  - Round-robin: search starts at `last+1` mod `N_REQ`. `last` is the most recent grant and resets to `N_REQ-1`, so requester 0 has first priority after reset.
- **Request rules**
  - Dropping `req` mid-job has no effect. The job completes and is acked.
  - A requester must deassert `req` in the cycle after `ack` or it is re-served.
  - `data` changes after grant are ignored.

## Timing
- Grant edge at cycle k. SHIFT occupies cycles k+1..k+W. DONE is cycle k+W+1. IDLE is cycle k+W+2.
- Request-to-result latency is W+1 cycles after the grant edge.
- The earliest next grant is the edge ending cycle k+W+2. Sustained throughput is one job per W+2 cycles.
- `req` is sampled only in IDLE, so requests arriving in SHIFT or DONE wait.
- Reset values: every output is 0, state = IDLE, detector = S0, count = 0, `last = N_REQ-1`.
- Reset mid-job (any state): the next cycle is IDLE with all outputs 0. The job is dropped with no `ack` and no `res_valid`.
- Simultaneous requests: exactly one grant per IDLE cycle, never two acks in one cycle.

## Configuration
- `SEQDET_FIXED_PRIO_EN`
  - Defined: fixed priority, lowest set index of `req` wins; `last` is unused.
  - Undefined (default): round-robin as above.
  - All other behaviour and timing are identical in both builds.

## Test plan
- Requester 0 alone, `data[15:0]=16'h9249`, grant at k → `res_valid`, `ack=4'b0001` at k+17; `res_count=5`, `res_hit=1`, `res_id=0`.
- Requester 2 with `16'h0000`, then `16'hFFFF` → `res_count=0`, `res_hit=0` for both; `res_id=2`.
- All four `req` held high continuously → `res_id` sequence 0,1,2,3,0, acks 18 cycles apart. With `SEQDET_FIXED_PRIO_EN` defined → 0,0,0,…
- `CNT_W=2`, word `16'h9249` → `res_count=3` (saturated), `res_hit=1`.
- `rst` pulsed during SHIFT cycle k+5 → outputs 0 from the following cycle, no `ack` for the job. With `req=4'b1111` afterwards, the next grant is `res_id=0`.
- Requester 1 drops `req` at k+3 and `data` changes at k+2 → job completes at k+17 using the word sampled at grant, and `ack[1]` pulses.
